// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the scanned BCD counter.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic logic is_bcd(bcd_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_counter_scan_cell.sv
// One BCD digit register with ripple carry/borrow to the next digit.
import bcd_pkg::*;

module bcd_digit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  input  logic load,
  input  bcd_t ld_val,
  output bcd_t q,
  output logic carry_out,
  output logic borrow_out
);

  assign carry_out  = inc && (q == BCD_MAX);
  assign borrow_out = dec && (q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= ld_val;
    end else if (inc) begin
      q <= carry_out ? 4'd0 : q + 4'd1;
    end else if (dec) begin
      q <= borrow_out ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_scan.sv
// Multi-digit BCD up/down counter with a free-running digit scan-out.
import bcd_pkg::*;

module bcd_counter_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    en,
  input  logic                    up_dn,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    carry,
  output logic                    load_err,
  output logic [3:0]              d_out,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic            ld_ok;
  logic            cnt_go;
  logic [NUM_DIGITS:0] inc_c;
  logic [NUM_DIGITS:0] dec_c;
  bcd_t            q [NUM_DIGITS];

  always_comb begin
    ld_ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!is_bcd(load_val[4*i +: 4])) ld_ok = 1'b0;
    end
  end

  // A rejected load still blocks counting that cycle.
  assign cnt_go   = en && !clr && !load;
  assign inc_c[0] = cnt_go && up_dn;
  assign dec_c[0] = cnt_go && !up_dn;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_cell u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_c[i]),
      .dec       (dec_c[i]),
      .clr       (clr),
      .load      (load && ld_ok),
      .ld_val    (load_val[4*i +: 4]),
      .q         (q[i]),
      .carry_out (inc_c[i+1]),
      .borrow_out(dec_c[i+1])
    );
    assign count[4*i +: 4] = q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= inc_c[NUM_DIGITS] || dec_c[NUM_DIGITS];
      load_err <= !clr && load && !ld_ok;
    end
  end

  logic [DW-1:0]         div;
  logic [IW-1:0]         idx;
  bcd_t                  cur;
  logic [NUM_DIGITS-1:0] sel;

  always_comb begin
    cur = '0;
    sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur    = q[i];
        sel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      idx     <= '0;
      d_out   <= '0;
      dig_sel <= NUM_DIGITS'(1);
    end else begin
      d_out   <= cur;
      dig_sel <= sel;
      if (div == DW'(SCAN_DIV - 1)) begin
        div <= '0;
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule
